// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: operation codes, FSM state
// encoding and the default datapath width of the downstream ALU.
package alu_pkg;

    localparam int ALU_DATA_W = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_PASS = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the 8-bit ALU: registers operands onto the ALU,
// captures its result one cycle later and hands it downstream.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_use_acc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic [DATA_W-1:0] acc,
    output logic [CNT_W-1:0]  op_count
);

    issue_state_e      state_r;
    logic [DATA_W-1:0] alu_a_r;
    logic [DATA_W-1:0] alu_b_r;
    logic [2:0]        alu_sel_r;
    logic              res_valid_r;
    logic [DATA_W-1:0] res_data_r;
    logic              res_zero_r;
    logic [DATA_W-1:0] acc_r;
    logic [CNT_W-1:0]  op_count_r;
    logic              cmd_ready_s;
    logic              cmd_fire_s;
    logic              res_fire_s;

    // Ready depends only on state; in DONE a new command can ride on the result handshake.
    always_comb begin
        cmd_ready_s = 1'b0;
        case (state_r)
            IDLE:    cmd_ready_s = 1'b1;
            EXEC:    cmd_ready_s = 1'b0;
            DONE:    cmd_ready_s = res_ready;
            default: cmd_ready_s = 1'b0;
        endcase
    end

    assign cmd_fire_s = cmd_valid & cmd_ready_s;
    assign res_fire_s = res_valid_r & res_ready;

    // Issue FSM together with operand, result, accumulator and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            alu_a_r     <= {DATA_W{1'b0}};
            alu_b_r     <= {DATA_W{1'b0}};
            alu_sel_r   <= 3'b000;
            res_valid_r <= 1'b0;
            res_data_r  <= {DATA_W{1'b0}};
            res_zero_r  <= 1'b0;
            acc_r       <= {DATA_W{1'b0}};
            op_count_r  <= {CNT_W{1'b0}};
        end else begin
            if (res_fire_s) begin
                op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            // acc_r still holds the previous result here, so chaining in DONE sees it.
            if (cmd_fire_s) begin
                alu_a_r   <= cmd_use_acc ? acc_r : cmd_a;
                alu_b_r   <= cmd_b;
                alu_sel_r <= cmd_op;
            end
            case (state_r)
                IDLE: begin
                    if (cmd_fire_s) begin
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    res_data_r  <= alu_out;
                    res_zero_r  <= alu_zero;
                    acc_r       <= alu_out;
                    res_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        state_r     <= cmd_valid ? EXEC : IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_s;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_sel   = alu_sel_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_zero  = res_zero_r;
    assign acc       = acc_r;
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural 8-bit ALU attached
// and a transaction-level reference model (expected results, acc, op count).
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [DW-1:0] cmd_a;
    logic [DW-1:0] cmd_b;
    logic          cmd_use_acc;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_sel;
    logic [DW-1:0] alu_out;
    logic          alu_zero;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          res_zero;
    logic [DW-1:0] acc;
    logic [CW-1:0] op_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_acc;
    logic [CW-1:0] m_cnt;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_zero(res_zero),
        .acc(acc), .op_count(op_count)
    );

    // Stand-in for ALU_8bit: combinational, results truncated to 8 bits.
    always_comb begin
        alu_out = 8'h00;
        case (alu_sel)
            3'b000:  alu_out = alu_a + alu_b;
            3'b001:  alu_out = alu_a - alu_b;
            3'b010:  alu_out = alu_a & alu_b;
            3'b011:  alu_out = alu_a | alu_b;
            3'b100:  alu_out = alu_a ^ alu_b;
            3'b101:  alu_out = alu_a << 1;
            3'b110:  alu_out = alu_a >> 1;
            default: alu_out = alu_a;
        endcase
        alu_zero = (alu_out == 8'h00);
    end

    function automatic logic [DW-1:0] ref_alu(input int op, input int a, input int b);
        int r;
        case (op)
            0: r = a + b;
            1: r = a - b + 256;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a * 2;
            6: r = a / 2;
            default: r = a;
        endcase
        return r[DW-1:0];
    endfunction

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_a = 8'h00; cmd_b = 8'h00;
        cmd_use_acc = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        m_acc = 8'h00; m_cnt = 4'd0;
        checks++;
        if ({res_valid, res_data, res_zero, acc, op_count, alu_a, alu_b, alu_sel, cmd_ready}
            !== {1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 8'h00, 8'h00, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL reset: valid=%0b data=%h zero=%0b acc=%h cnt=%0d a=%h b=%h sel=%0d rdy=%0b, required all zero and ready=1",
                     res_valid, res_data, res_zero, acc, op_count, alu_a, alu_b, alu_sel, cmd_ready);
        end
    endtask

    // One full transaction from IDLE with a chosen stall, checking every phase.
    task automatic do_op(input int op, input int a, input int b, input bit ua, input int stall);
        logic [DW-1:0] ea;
        logic [DW-1:0] er;
        ea = ua ? m_acc : a[DW-1:0];
        er = ref_alu(op, int'(ea), b);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op[2:0]; cmd_a = a[DW-1:0]; cmd_b = b[DW-1:0];
        cmd_use_acc = ua; res_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL idle_ready: got %0b required 1", cmd_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({alu_a, alu_b, alu_sel, res_valid, cmd_ready} !== {ea, b[DW-1:0], op[2:0], 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL issue: a=%h b=%h sel=%0d valid=%0b rdy=%0b required a=%h b=%h sel=%0d valid=0 rdy=0",
                     alu_a, alu_b, alu_sel, res_valid, cmd_ready, ea, b[DW-1:0], op);
        end
        @(negedge clk) cmd_valid = 1'b0;
        @(posedge clk); #1;
        m_acc = er;
        checks++;
        if ({res_valid, res_data, res_zero, acc} !== {1'b1, er, (er == 8'h00), er}) begin
            errors++;
            $display("FAIL result op%0d: valid=%0b data=%h zero=%0b acc=%h required 1 %h %0b %h",
                     op, res_valid, res_data, res_zero, acc, er, (er == 8'h00), er);
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({res_valid, res_data, res_zero, cmd_ready, op_count, alu_a}
                !== {1'b1, er, (er == 8'h00), 1'b0, m_cnt, ea}) begin
                errors++;
                $display("FAIL stall%0d: valid=%0b data=%h zero=%0b rdy=%0b cnt=%0d a=%h required 1 %h %0b 0 %0d %h",
                         i, res_valid, res_data, res_zero, cmd_ready, op_count, alu_a, er, (er == 8'h00), m_cnt, ea);
            end
        end
        @(negedge clk) res_ready = 1'b1;
        @(posedge clk); #1;
        m_cnt = m_cnt + 4'd1;
        checks++;
        if ({res_valid, op_count, cmd_ready} !== {1'b0, m_cnt, 1'b1}) begin
            errors++;
            $display("FAIL handshake: valid=%0b cnt=%0d rdy=%0b required 0 %0d 1", res_valid, op_count, cmd_ready, m_cnt);
        end
        @(negedge clk) res_ready = 1'b0;
    endtask

    task automatic test_add();
        do_op(0, 8'h0A, 8'h05, 1'b0, 0);
        checks++;
        if ({res_data, acc, op_count} !== {8'h0F, 8'h0F, 4'd1}) begin
            errors++; $display("FAIL add: data=%h acc=%h cnt=%0d required 0f 0f 1", res_data, acc, op_count);
        end
    endtask

    task automatic test_chain();
        do_op(1, 8'h33, 8'h0F, 1'b1, 0);
        checks++;
        if ({alu_a, res_data, res_zero, acc} !== {8'h0F, 8'h00, 1'b1, 8'h00}) begin
            errors++; $display("FAIL chain: a=%h data=%h zero=%0b acc=%h required 0f 00 1 00", alu_a, res_data, res_zero, acc);
        end
    endtask

    task automatic test_backpressure();
        do_op(0, 8'h0A, 8'h05, 1'b0, 5);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_AND; cmd_a = 8'hFF; cmd_b = 8'h0F; cmd_use_acc = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); cmd_op = OP_OR; cmd_a = 8'hF0; cmd_b = 8'h0F;
        @(posedge clk); #1;
        checks++;
        if ({res_valid, res_data, cmd_ready} !== {1'b1, 8'h0F, 1'b1}) begin
            errors++; $display("FAIL b2b_first: valid=%0b data=%h rdy=%0b required 1 0f 1", res_valid, res_data, cmd_ready);
        end
        @(posedge clk); #1;
        m_cnt = m_cnt + 4'd1;
        @(negedge clk) cmd_valid = 1'b0;
        checks++;
        if ({res_valid, alu_a, alu_sel, op_count} !== {1'b0, 8'hF0, 3'b011, m_cnt}) begin
            errors++; $display("FAIL b2b_accept: valid=%0b a=%h sel=%0d cnt=%0d required 0 f0 3 %0d", res_valid, alu_a, alu_sel, op_count, m_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if ({res_valid, res_data, acc} !== {1'b1, 8'hFF, 8'hFF}) begin
            errors++; $display("FAIL b2b_second: valid=%0b data=%h acc=%h required 1 ff ff", res_valid, res_data, acc);
        end
        @(posedge clk); #1;
        m_cnt = m_cnt + 4'd1;
        m_acc = 8'hFF;
        checks++;
        if ({res_valid, op_count} !== {1'b0, m_cnt}) begin
            errors++; $display("FAIL b2b_done: valid=%0b cnt=%0d required 0 %0d", res_valid, op_count, m_cnt);
        end
        @(negedge clk) res_ready = 1'b0;
    endtask

    task automatic test_random(input int n);
        for (int k = 0; k < n; k++) begin
            do_op($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
    endtask

    task automatic test_wrap();
        int guard = 0;
        do begin
            do_op($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 0);
            guard++;
        end while (m_cnt != 4'd0 && guard < 40);
        checks++;
        if (op_count !== 4'd0) begin
            errors++; $display("FAIL wrap: cnt=%0d required 0", op_count);
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 8'h12; cmd_b = 8'h34; cmd_use_acc = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk) begin cmd_valid = 1'b0; rst = 1'b1; end
        @(posedge clk); #1;
        checks++;
        if ({res_valid, res_data, res_zero, acc, op_count, alu_a, alu_b, alu_sel, cmd_ready}
            !== {1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 8'h00, 8'h00, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid: valid=%0b data=%h acc=%h cnt=%0d a=%h b=%h sel=%0d rdy=%0b required all zero and ready=1",
                     res_valid, res_data, acc, op_count, alu_a, alu_b, alu_sel, cmd_ready);
        end
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({res_valid, op_count} !== {1'b0, 4'd0}) begin
            errors++; $display("FAIL reset_mid_after: valid=%0b cnt=%0d required 0 0", res_valid, op_count);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_chain();
        test_backpressure();
        test_back_to_back();
        test_random(30);
        test_wrap();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
